// File: rtl/spi_ram_slave.sv
// -----------------------------------------------------------------------------
// spi_ram_slave
//   SPI slave with an embedded MEM_DEPTH x DATA_WIDTH RAM. Each SS_n-low frame
//   starts with a 2-bit command (MSB first), followed by payload words:
//     00 : load write pointer (any number of words, last completed wins)
//     01 : write data burst at wr_ptr (pointer advances if AUTO_INC)
//     10 : load read pointer
//     11 : read data burst from rd_ptr, streamed MSB first on MISO
//   Pointers persist across frames and wrap modulo MEM_DEPTH.
//
// Ports
//   clk   in  SPI clock, all logic on the rising edge
//   rst_n in  asynchronous active-low reset (RAM contents are not reset)
//   SS_n  in  slave select, active low, frame in progress while low
//   MOSI  in  serial data in, MSB first
//   MISO  out registered serial data out, 0 outside read data edges
// -----------------------------------------------------------------------------
module spi_ram_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Pointer step after each burst word: 1 with auto-increment, 0 to hold.
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP =
    (AUTO_INC != 0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WR_ADDR = 3'd2;
  localparam logic [2:0] ST_WR_DATA = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;

  logic [2:0]            state_q,    state_d;
  logic                  cmd_hi_q,   cmd_hi_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic                  miso_q,     miso_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic [DATA_WIDTH-1:0] rx_word_s;
  logic                  mem_we_s;
  logic                  word_end_s;

  // Combinational RAM read feeding the transmit shifter without wait cycles.
  assign mem_rdata_s = mem_q[rd_ptr_q];
  // Received word including the bit sampled on this edge (low W bits kept).
  assign rx_word_s   = DATA_WIDTH'({rx_shift_q, MOSI});
  assign word_end_s  = (cnt_q == CNT_LAST);
  assign MISO        = miso_q;

  // Next-state logic: command decode, payload framing and pointer updates.
  always_comb begin
    state_d    = state_q;
    cmd_hi_d   = cmd_hi_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    miso_d     = 1'b0;
    mem_we_s   = 1'b0;
    if (SS_n) begin
      // Frame end or gap: a partial word is simply dropped.
      state_d    = ST_IDLE;
      cnt_d      = CNT_ZERO;
      rx_shift_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_hi_d = MOSI;
          state_d  = ST_CMD;
        end
        ST_CMD: begin
          cnt_d      = CNT_ZERO;
          rx_shift_d = '0;
          case ({cmd_hi_q, MOSI})
            2'b00:   state_d = ST_WR_ADDR;
            2'b01:   state_d = ST_WR_DATA;
            2'b10:   state_d = ST_RD_ADDR;
            2'b11: begin
              // First read word is fetched on the second command edge.
              state_d    = ST_RD_DATA;
              tx_shift_d = mem_rdata_s;
              rd_ptr_d   = rd_ptr_q + PTR_STEP;
            end
            default: state_d = ST_IDLE;
          endcase
        end
        ST_WR_ADDR, ST_RD_ADDR, ST_WR_DATA: begin
          rx_shift_d = rx_word_s;
          if (word_end_s) begin
            cnt_d = CNT_ZERO;
            case (state_q)
              ST_WR_ADDR: wr_ptr_d = rx_word_s[ADDR_WIDTH-1:0];
              ST_RD_ADDR: rd_ptr_d = rx_word_s[ADDR_WIDTH-1:0];
              ST_WR_DATA: begin
                mem_we_s = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_STEP;
              end
              default: cnt_d = CNT_ZERO;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RD_DATA: begin
          miso_d     = tx_shift_q[DATA_WIDTH-1];
          tx_shift_d = tx_shift_q << 1;
          if (word_end_s) begin
            // Last bit of this word goes out now; next word loads back-to-back.
            cnt_d      = CNT_ZERO;
            tx_shift_d = mem_rdata_s;
            rd_ptr_d   = rd_ptr_q + PTR_STEP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_hi_q   <= 1'b0;
      cnt_q      <= CNT_ZERO;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_hi_q   <= cmd_hi_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      miso_q     <= miso_d;
    end
  end

  // RAM array: contents survive reset, written on a word's last bit.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= rx_word_s;
    end
  end

endmodule

// File: doc/spi_ram_slave.md
# spi_ram_slave

Parametrised successor to the SPI slave + single-port RAM pair: one module that deserialises SPI frames, owns a `MEM_DEPTH` x `DATA_WIDTH` RAM, and serialises read data back on `MISO`. It generalises word width and depth and adds burst transfers with optional address auto-increment inside one `SS_n`-low frame. It sits directly on the chip's SPI pins; the SPI clock is `clk`.

## Interface
- `DATA_WIDTH`, default 8: payload and RAM word width (W).
- `MEM_DEPTH`, default 256: RAM words; power of 2, at least 2.
- `ADDR_WIDTH`, default $clog2(MEM_DEPTH): pointer width; must be at most `DATA_WIDTH`.
- `AUTO_INC`, default 1: 1 = pointer +1 after each burst word; 0 = pointer holds.
- `clk`  in  1  SPI/system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low; low = frame in progress.
- `MOSI`  in  1  serial data in, MSB first, sampled on rising `clk`.
- `MISO`  out  1  serial data out, registered, updated on rising `clk`.

## Operation
- Edge index k: the k-th rising edge with `SS_n` sampled low in the current frame, k=0 first.
- k=0,1: command bits c[1] then c[0]. States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA.
- c=00 WR_ADDR: edges k=2..W+1 shift payload; at k=W+1, `wr_ptr` <= payload[ADDR_WIDTH-1:0]. Upper payload bits ignored.
- c=10 RD_ADDR: same framing, loads `rd_ptr`.
- c=01 WR_DATA: payload word n spans edges k=2+nW .. 1+(n+1)W. At the last edge of each word: mem[wr_ptr] <= word, and `wr_ptr` <= wr_ptr+1 (mod MEM_DEPTH) if `AUTO_INC`.
- c=11 RD_DATA: no payload; `MOSI` ignored.
  - At k=1: tx_shift <= mem[rd_ptr]; `rd_ptr` increments if `AUTO_INC`.
  - At k=2+nW+j (j=0..W-1): `MISO` <= tx_shift[W-1-j].
  - At j=W-1: tx_shift reloads from mem[rd_ptr]; `rd_ptr` increments if `AUTO_INC`.
- Bursts continue for as long as `SS_n` stays low. WR_ADDR/RD_ADDR accept any further words and re-load the pointer on each completed word.
- `SS_n` high on any edge:
  - State goes to IDLE and `MISO` <= 0.
  - A partial word is discarded: no RAM write, no pointer change. Completed words stay committed.
- `wr_ptr` and `rd_ptr` persist across frames and are independent.
- `MISO` is 0 in every state except RD_DATA data edges.
- Pointers wrap from MEM_DEPTH-1 to 0.

## Timing
- Reset values: `MISO`=0, state=IDLE, `wr_ptr`=0, `rd_ptr`=0, shift registers 0. RAM contents are not reset.
- Reset is asynchronous: outputs clear immediately on `rst_n` low, regardless of `clk`. A frame in progress is aborted with no write. After release, the next `SS_n`-low edge is k=0.
- Write latency: RAM is updated at the edge sampling the word's last bit. A read in any later frame returns the new value.
- Read latency: first data bit appears on `MISO` after edge k=2. The master samples each bit after its edge, before the next one.
- Frames must be separated by at least one edge with `SS_n` high. A frame shorter than 2 edges does nothing.
- The RAM read is combinational into tx_shift; there are no extra wait cycles between burst words.

## Test plan
- Reset: assert `rst_n` low mid-idle -> `MISO`=0 and both pointers 0 immediately. Then frame 11 -> reads mem[0] (preload via write first).
- Single write/read (W=8, depth 256): frames 00+0x10, 01+0xA5, 10+0x10, 11 -> `MISO` = 1,0,1,0,0,1,0,1 after edges k=2..9; `MISO`=0 elsewhere.
- Burst with wrap, `AUTO_INC`=1: frames 00+0xFE, 01+0x11,0x22,0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, `wr_ptr`=0x01. Then 10+0xFE, 11 for 24 bits -> `MISO` streams 0x11, 0x22, 0x33 with no gaps; `rd_ptr`=0x02 after the frame.
- Abort: after mem[0x20]=0x5A, frames 00+0x20, then 01 followed by 5 bits and `SS_n` high -> mem[0x20] still 0x5A, `wr_ptr`=0x20, `MISO`=0, state IDLE.
- `AUTO_INC`=0: frames 00+0x04, 01+0x01,0x02,0x03 -> mem[0x04]=0x03, mem[0x05] untouched. Then 10+0x04, 11 for 16 bits -> 0x03, 0x03.
- Reset mid-burst: `rst_n` low at k=6 of a 01 frame with `wr_ptr`=0x30 -> no write to mem[0x30], `wr_ptr`=0, `MISO`=0. The next frame 00+0x31, 01+0x77 writes mem[0x31]=0x77.
